// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed common-anode 7-segment driver for a hex word.
// The shown word is swapped only at frame boundaries (double buffered), digits
// advance on a refresh prescaler, and leading zero digits may be blanked.
// load is a single-cycle strobe with no backpressure: value is captured on
// every rising edge where load=1, and the last capture before a frame boundary wins.
module hex_display_scan #(
  parameter int BITS        = 16,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1,
  localparam int NDIG       = (BITS + 3) / 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [BITS-1:0] value,
  output logic [6:0]      seg,
  output logic [NDIG-1:0] an,
  output logic            frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX   = DW'(NDIG - 1);

  if (REFRESH_DIV < 1) begin : g_bad_refresh_div
    $error("hex_display_scan: REFRESH_DIV must be >= 1");
  end

  logic [BITS-1:0]   pending;
  logic [BITS-1:0]   disp;
  logic [PW-1:0]     presc;
  logic [DW-1:0]     dig;
  logic              tick;
  logic              boundary;
  logic [4*NDIG-1:0] dpad;
  logic [3:0]        nib;
  logic              hi_nz;
  logic              blank;
  logic [NDIG-1:0]   an_next;

  assign tick     = (presc == PRESC_MAX);
  assign boundary = tick && (dig == DIG_MAX);
  // Zero-extend so a partial top nibble reads as a full nibble.
  assign dpad     = (4*NDIG)'(disp);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Select the current digit's nibble, its anode, and whether it is a leading zero.
  always_comb begin
    nib     = 4'h0;
    hi_nz   = 1'b0;
    an_next = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (DW'(i) == dig) begin
        nib        = dpad[4*i +: 4];
        an_next[i] = 1'b0;
      end
      if ((i >= int'(dig)) && (dpad[4*i +: 4] != 4'h0)) hi_nz = 1'b1;
    end
    blank = BLANK_LZ && (dig != '0) && !hi_nz;
  end

  // Refresh prescaler, digit scan counter and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      dig        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        presc <= '0;
        dig   <= boundary ? '0 : dig + DW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Capture loads; publish the newest word only at a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      disp    <= '0;
    end else begin
      if (load) pending <= value;
      if (boundary) disp <= load ? value : pending;
    end
  end

  // Registered display outputs, one clock behind dig/disp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'h7F;
      an  <= '1;
    end else begin
      seg <= blank ? 7'h7F : hex7(nib);
      an  <= blank ? '1 : an_next;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// tb_hex_display_scan: three configurations of hex_display_scan checked every
// cycle against a cycle-count based behavioural model, plus literal scenarios.
module tb_hex_display_scan;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [6:0]  seg_a, seg_b, seg_c;
  logic [3:0]  an_a, an_b;
  logic [2:0]  an_c;
  logic        fd_a, fd_b, fd_c;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Per-instance configuration: A = 16b/div4/blank, B = 16b/div4/no blank, C = 10b/div1/blank.
  int          divs [3] = '{4, 4, 1};
  int          nds  [3] = '{4, 4, 3};
  int          blzs [3] = '{1, 0, 1};
  logic [15:0] masks[3] = '{16'hFFFF, 16'hFFFF, 16'h03FF};

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_scan #(.BITS(16), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .seg(seg_a), .an(an_a), .frame_done(fd_a));

  hex_display_scan #(.BITS(16), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .seg(seg_b), .an(an_b), .frame_done(fd_b));

  hex_display_scan #(.BITS(10), .REFRESH_DIV(1), .BLANK_LZ(1'b1)) u_c (
    .clk(clk), .rst(rst), .load(load), .value(value[9:0]),
    .seg(seg_c), .an(an_c), .frame_done(fd_c));

  logic [6:0] dseg [3];
  logic [3:0] dan  [3];
  logic       dfd  [3];
  assign dseg[0] = seg_a;  assign dan[0] = an_a;          assign dfd[0] = fd_a;
  assign dseg[1] = seg_b;  assign dan[1] = an_b;          assign dfd[1] = fd_b;
  assign dseg[2] = seg_c;  assign dan[2] = {1'b0, an_c};  assign dfd[2] = fd_c;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic bit m_blank(input logic [15:0] v, input int d, input int blz);
    logic [15:0] hi;
    hi = v >> (4*d);
    return (blz != 0) && (d > 0) && (hi == 16'h0);
  endfunction

  function automatic logic [6:0] m_seg(input logic [15:0] v, input int d, input int blz);
    logic [15:0] hi;
    hi = v >> (4*d);
    if (m_blank(v, d, blz)) return 7'h7F;
    return hex_tbl[hi[3:0]];
  endfunction

  function automatic logic [3:0] m_an(input logic [15:0] v, input int d, input int nd, input int blz);
    logic [3:0] full;
    full = 4'((1 << nd) - 1);
    if (m_blank(v, d, blz)) return full;
    return full & ~4'(1 << d);
  endfunction

  // Edge k after reset scans digit (k/div)%nd; the frame ends on the last edge of each nd*div block.
  function automatic bit m_bnd(input int k, input int i);
    return (k % (nds[i]*divs[i])) == (nds[i]*divs[i] - 1);
  endfunction

  int          mk    [3];
  logic [15:0] mpend [3];
  logic [15:0] mdisp [3];
  logic [6:0]  mseg  [3];
  logic [3:0]  man   [3];
  logic        mfd   [3];

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mk[i]    <= 0;
        mpend[i] <= 16'h0;
        mdisp[i] <= 16'h0;
        mseg[i]  <= 7'h7F;
        man[i]   <= 4'((1 << nds[i]) - 1);
        mfd[i]   <= 1'b0;
      end else begin
        mseg[i] <= m_seg(mdisp[i], (mk[i] / divs[i]) % nds[i], blzs[i]);
        man[i]  <= m_an(mdisp[i], (mk[i] / divs[i]) % nds[i], nds[i], blzs[i]);
        mfd[i]  <= m_bnd(mk[i], i);
        if (load) mpend[i] <= value & masks[i];
        if (m_bnd(mk[i], i)) mdisp[i] <= load ? (value & masks[i]) : mpend[i];
        mk[i]   <= mk[i] + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("seg%0d", i), int'(dseg[i]), int'(mseg[i]));
        check($sformatf("an%0d", i),  int'(dan[i]),  int'(man[i]));
        check($sformatf("fd%0d", i),  int'(dfd[i]),  int'(mfd[i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd(input int inst);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (dfd[inst]) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL wait_fd%0d actual=timeout expected=pulse", inst);
    end
  endtask

  // Called on the negedge showing frame_done; checks the four slots of the next frame.
  task automatic frame_lit(input string tag, input int inst, input logic [27:0] segs, input logic [15:0] ans);
    for (int j = 0; j < 4; j++) begin
      repeat ((j == 0) ? 1 : 4) @(negedge clk);
      check($sformatf("%s_seg%0d", tag, j), int'(dseg[inst]), int'(segs[7*j +: 7]));
      check($sformatf("%s_an%0d", tag, j),  int'(dan[inst]),  int'(ans[4*j +: 4]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_a, n_c;
    logic [20:0] c_segs;
    logic [11:0] c_ans;
    rst = 1'b1; load = 1'b0; value = 16'h0;

    // pin the model with hand-computed digits
    check("m_1a3f_d0", int'(m_seg(16'h1A3F, 0, 1)), 'h0E);
    check("m_1a3f_d3", int'(m_seg(16'h1A3F, 3, 1)), 'h79);
    check("m_00f0_d2", int'(m_seg(16'h00F0, 2, 1)), 'h7F);
    check("m_00f0_an2", int'(m_an(16'h00F0, 2, 4, 1)), 'hF);
    check("m_00f0_nb", int'(m_an(16'h00F0, 2, 4, 0)), 'hB);
    check("m_3ff_d2", int'(m_seg(16'h03FF, 2, 1)), 'h30);

    repeat (3) @(negedge clk);
    run_cmp = 1'b1;
    check("rst_seg", int'(seg_a), 'h7F);
    check("rst_an", int'(an_a), 'hF);
    rst = 1'b0;

    // 1: after release show a single "0"
    @(negedge clk);
    check("rel_seg", int'(seg_a), 'h40);
    check("rel_an", int'(an_a), 'hE);
    repeat (4) @(negedge clk);
    check("rel_blank_an", int'(an_a), 'hF);
    n_a = 0; n_c = 0;
    repeat (48) begin
      @(negedge clk);
      if (fd_a) n_a++;
      if (fd_c) n_c++;
    end
    check("fd_count_a", n_a, 3);
    check("fd_count_c", n_c, 16);

    // 2: 1A3F shown starting the next frame
    do_load(16'h1A3F);
    wait_fd(0);
    frame_lit("s2", 0, {7'h79, 7'h08, 7'h30, 7'h0E}, {4'h7, 4'hB, 4'hD, 4'hE});

    // 3: leading zero blanking on A, full display on B
    do_load(16'h00F0);
    wait_fd(0);
    frame_lit("s3a", 0, {7'h7F, 7'h7F, 7'h0E, 7'h40}, {4'hF, 4'hF, 4'hD, 4'hE});
    wait_fd(1);
    frame_lit("s3b", 1, {7'h40, 7'h40, 7'h0E, 7'h40}, {4'h7, 4'hB, 4'hD, 4'hE});

    // 4: load on the boundary edge, then a mid-frame load
    wait_fd(0);
    repeat (15) @(negedge clk);
    value = 16'h1111;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("s4_bnd_fd", int'(fd_a), 1);
    frame_lit("s4a", 0, {7'h79, 7'h79, 7'h79, 7'h79}, {4'h7, 4'hB, 4'hD, 4'hE});
    do_load(16'h2222);
    wait_fd(0);
    frame_lit("s4b", 0, {7'h24, 7'h24, 7'h24, 7'h24}, {4'h7, 4'hB, 4'hD, 4'hE});

    // 5: asynchronous reset discards a pending BEEF
    value = 16'hBEEF;
    load  = 1'b1;
    @(posedge clk);
    #2;
    load = 1'b0;
    rst  = 1'b1;
    #1;
    check("s5_async_seg", int'(seg_a), 'h7F);
    check("s5_async_an", int'(an_a), 'hF);
    check("s5_async_an_c", int'(an_c), 'h7);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fd(0);
    frame_lit("s5", 0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'hF, 4'hF, 4'hF, 4'hE});

    // 6: 10-bit word, one clock per digit
    do_load(16'h03FF);
    wait_fd(0);
    wait_fd(2);
    c_segs = {7'h30, 7'h0E, 7'h0E};
    c_ans  = {4'h3, 4'h5, 4'h6};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("s6_seg%0d", j), int'(seg_c), int'(c_segs[7*j +: 7]));
      check($sformatf("s6_an%0d", j), int'(an_c), int'(c_ans[4*j +: 4]));
    end

    // randomized loads with varied leading-zero depth
    repeat (800) begin
      @(negedge clk);
      load = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: value = 16'($urandom);
        1: value = 16'($urandom) & 16'h00FF;
        2: value = 16'($urandom) & 16'h000F;
        default: value = 16'h0;
      endcase
    end
    load = 1'b0;
    repeat (40) @(negedge clk);

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
